synapse_weight_bank_array: RTL

//  Multi-bank synaptic weight store for the Izhikevich neuron array: NUM_BANKS independent banks of

---
 rtl/neuron_mem_pkg.sv | 38 +++
 rtl/synapse_weight_ram.sv | 31 +++
 rtl/synapse_weight_bank_array.sv | 139 +++++++++++++
 3 files changed

// File: rtl/neuron_mem_pkg.sv
// Shared types and helpers for the synaptic weight bank array.
package neuron_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } sat_res_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Unsigned weight plus signed delta, clamped to [0, 2^width-1]; width <= 63.
    function automatic sat_res_t sat_add(input logic [63:0] w, input logic [63:0] d_sext,
                                         input int width);
        logic signed [65:0] sum;
        logic        [65:0] maxv;
        sat_res_t           r;
        sum   = $signed({2'b00, w}) + $signed({d_sext[63], d_sext[63], d_sext});
        maxv  = (66'd1 << width) - 66'd1;
        r.sat = 1'b0;
        r.val = sum[63:0];
        if (sum < 66'sd0) begin
            r.sat = 1'b1;
            r.val = '0;
        end else if (sum > $signed(maxv)) begin
            r.sat = 1'b1;
            r.val = maxv[63:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/synapse_weight_ram.sv
// One weight bank: single write port, two asynchronous read ports.
module synapse_weight_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_L)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = ({1'b0, raddr_a} < DEPTH_L) ? mem[raddr_a] : '0;
    assign rdata_b = ({1'b0, raddr_b} < DEPTH_L) ? mem[raddr_b] : '0;

endmodule

// File: rtl/synapse_weight_bank_array.sv
// NUM_BANKS parallel weight banks with registered wide read, saturating update and
// a clear sequencer that zeroes all banks after reset or on clr_start.
module synapse_weight_bank_array
    import neuron_mem_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int DELTA_W   = 8,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int BANK_W   = clog2_min1(NUM_BANKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_start,
    output logic                       busy,
    input  logic                       wr_en,
    input  logic [BANK_W-1:0]          wr_bank,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       upd_en,
    input  logic [BANK_W-1:0]          upd_bank,
    input  logic [ADDR_W-1:0]          upd_addr,
    input  logic [DELTA_W-1:0]         upd_delta,
    output logic                       upd_sat,
    output logic                       upd_drop,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [NUM_BANKS*WIDTH-1:0] rd_data,
    output logic                       rd_valid
);

    localparam int                NSLOT = 1 << BANK_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    clr_state_t               state;
    logic [ADDR_W-1:0]        clr_cnt;
    logic                     clearing;
    logic [NSLOT-1:0]         bank_mask;
    logic                     wr_ok;
    logic                     upd_ok;
    logic                     upd_drop_n;
    logic [WIDTH-1:0]         upd_word_arr [NSLOT];
    logic [WIDTH-1:0]         upd_word;
    logic [63:0]              delta_sext;
    sat_res_t                 sat_r;
    logic [WIDTH-1:0]         upd_val;
    logic                     unused_sat_hi;
    logic [ADDR_W-1:0]        ram_waddr;
    logic [WIDTH-1:0]         ram_wdata;
    logic [NUM_BANKS*WIDTH-1:0] rd_flat;

    assign clearing = (state == CLEAR);

    // Write priority: clear sequencer, then direct write, then update.
    assign wr_ok      = !clearing && wr_en && bank_mask[wr_bank];
    assign upd_ok     = !clearing && upd_en && !wr_en && bank_mask[upd_bank];
    assign upd_drop_n = !clearing && upd_en && (wr_en || !bank_mask[upd_bank]);

    assign upd_word      = upd_word_arr[upd_bank];
    assign delta_sext    = {{(64 - DELTA_W){upd_delta[DELTA_W-1]}}, upd_delta};
    assign sat_r         = sat_add({{(64 - WIDTH){1'b0}}, upd_word}, delta_sext, WIDTH);
    assign upd_val       = sat_r.val[WIDTH-1:0];
    assign unused_sat_hi = ^sat_r.val[63:WIDTH];

    assign ram_waddr = clearing ? clr_cnt : (wr_en ? wr_addr : upd_addr);
    assign ram_wdata = clearing ? '0      : (wr_en ? wr_data : upd_val);

    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        assign bank_mask[s] = (s < NUM_BANKS);
        if (s < NUM_BANKS) begin : g_bank
            logic we_b;
            assign we_b = clearing
                        || (wr_ok  && (wr_bank  == BANK_W'(s)))
                        || (upd_ok && (upd_bank == BANK_W'(s)));
            synapse_weight_ram #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_ram (
                .clk     (clk),
                .we      (we_b),
                .waddr   (ram_waddr),
                .wdata   (ram_wdata),
                .raddr_a (rd_addr),
                .rdata_a (rd_flat[s*WIDTH +: WIDTH]),
                .raddr_b (upd_addr),
                .rdata_b (upd_word_arr[s])
            );
        end else begin : g_pad
            assign upd_word_arr[s] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // rd_valid qualifies rd_data for exactly one cycle after an accepted rd_en; there is no
    // backpressure, and rd_data holds its last value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            upd_sat  <= 1'b0;
            upd_drop <= 1'b0;
        end else begin
            rd_valid <= !clearing && rd_en;
            if (!clearing && rd_en) begin
                rd_data <= rd_flat;
            end
            upd_sat  <= upd_ok && sat_r.sat;
            upd_drop <= upd_drop_n;
        end
    end

endmodule
